// File: rtl/toy_bus_pkg.sv
// Purpose  : shared ToyBusAck field widths and node id constants for the bus network.
// Latency  : n/a (declarations only).
// Backpres.: n/a (declarations only).
// Contents : field widths (ID_W, DATA_W, opcode), node ids shared with the decoder nodes,
//            and a width-aware wrap-increment helper used by round-robin pointers.
package toy_bus_pkg;

    // ToyBusAck field widths
    localparam int TB_ID_W     = 4;
    localparam int TB_DATA_W   = 32;
    localparam int TB_OPCODE_W = 1;

    // Node ids used as tgt_id / src_id values across the network
    localparam logic [TB_ID_W-1:0] NODE_ID_CORE = 4'h0;
    localparam logic [TB_ID_W-1:0] NODE_ID_LSU  = 4'h1;
    localparam logic [TB_ID_W-1:0] NODE_ID_DBG  = 4'h2;
    localparam logic [TB_ID_W-1:0] NODE_ID_DMA  = 4'h3;
    localparam logic [TB_ID_W-1:0] NODE_ID_MEM  = 4'h6;

    // Ack opcodes
    localparam logic OPC_ACK      = 1'b0;
    localparam logic OPC_ACK_DATA = 1'b1;

    // Index following idx in a ring of n entries (n-1 wraps to 0).
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/toy_bus_rr_arb.sv
// Purpose  : generic NUM_IN-wide round-robin grant; owns the rotating priority pointer.
// Latency  : grant is combinational from req/ptr; pointer moves on the clock after adv.
// Backpres.: grant is only a proposal; pointer advances only when the caller strobes adv.
// Ports    : clk, rst (sync, active-high), req[NUM_IN] requests, adv accept strobe,
//            gnt[NUM_IN] one-hot (or zero) winner.
module toy_bus_rr_arb
    import toy_bus_pkg::*;
#(
    parameter int NUM_IN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              adv,
    output logic [NUM_IN-1:0] gnt
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W:0]   scan_sum;
    logic             found;

    // Scan from ptr upward, wrapping modulo NUM_IN; first requester wins.
    // The sum is one bit wider so non-power-of-two NUM_IN wraps correctly.
    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        scan_sum = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_IN)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_IN);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
        if (found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // The input just served becomes lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) begin
            ptr_d = PTR_W'(rr_wrap_inc(int'(win_idx), NUM_IN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/toy_bus_arb_node_rr.sv
// Purpose  : round-robin merge of NUM_IN ToyBusAck streams into one registered output slot.
// Latency  : 1 cycle from accept to out_vld; full throughput (load-while-drain, no bubbles).
// Backpres.: in_rdy only for the granted input and only when the slot is free or draining.
// Ports    : clk, rst (sync, active-high); in_vld/in_rdy/in_opcode/in_data/in_src_id/in_tgt_id
//            packed per input (slice i = input i); out_vld/out_rdy + registered payload.
//            Optional TOY_BUS_ARB_STALL_CNT_EN adds stall_cnt[15:0] (saturating stall cycles).
module toy_bus_arb_node_rr
    import toy_bus_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int ID_W   = TB_ID_W,
    parameter int DATA_W = TB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_vld,
    output logic [NUM_IN-1:0]        in_rdy,
    input  logic [NUM_IN-1:0]        in_opcode,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN*ID_W-1:0]   in_src_id,
    input  logic [NUM_IN*ID_W-1:0]   in_tgt_id,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_opcode,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_src_id,
    output logic [ID_W-1:0]          out_tgt_id
`ifdef TOY_BUS_ARB_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   src_id;
        logic [ID_W-1:0]   tgt_id;
    } beat_t;

    beat_t             beat_q;
    beat_t             beat_d;
    beat_t             sel_beat;
    logic              out_vld_q;
    logic              out_vld_d;
    logic [NUM_IN-1:0] gnt;
    logic              slot_free;
    logic              accept;

    toy_bus_rr_arb #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (in_vld),
        .adv (accept),
        .gnt (gnt)
    );

    // Slot can take a new beat if empty or if its current beat leaves this cycle.
    assign slot_free = !out_vld_q || out_rdy;
    // Held low during reset so upstream never sees an accept that reset will drop.
    assign in_rdy    = rst ? '0 : (gnt & {NUM_IN{slot_free}});
    assign accept    = |(in_vld & in_rdy);

    // Payload mux driven by the one-hot grant.
    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                sel_beat.opcode = in_opcode[i];
                sel_beat.data   = in_data[i*DATA_W +: DATA_W];
                sel_beat.src_id = in_src_id[i*ID_W +: ID_W];
                sel_beat.tgt_id = in_tgt_id[i*ID_W +: ID_W];
            end
        end
    end

    // Payload is only rewritten on accept, so it stays stable while stalled
    // and keeps its last value after draining.
    always_comb begin
        out_vld_d = out_vld_q;
        beat_d    = beat_q;
        if (accept) begin
            out_vld_d = 1'b1;
            beat_d    = sel_beat;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            beat_q    <= beat_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_opcode = beat_q.opcode;
    assign out_data   = beat_q.data;
    assign out_src_id = beat_q.src_id;
    assign out_tgt_id = beat_q.tgt_id;

`ifdef TOY_BUS_ARB_STALL_CNT_EN
    // Saturating count of cycles the slot sat full against downstream backpressure.
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_vld_q && !out_rdy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_toy_bus_arb_node_rr.sv
module tb_toy_bus_arb_node_rr;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_vld;
    logic [N-1:0]    in_rdy;
    logic [N-1:0]    in_opcode;
    logic [N*DW-1:0] in_data;
    logic [N*IW-1:0] in_src_id;
    logic [N*IW-1:0] in_tgt_id;
    logic            out_vld;
    logic            out_rdy;
    logic            out_opcode;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_src_id;
    logic [IW-1:0]   out_tgt_id;
`ifdef TOY_BUS_ARB_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    toy_bus_arb_node_rr #(
        .NUM_IN (N),
        .ID_W   (IW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .in_src_id  (in_src_id),
        .in_tgt_id  (in_tgt_id),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .out_src_id (out_src_id),
        .out_tgt_id (out_tgt_id)
`ifdef TOY_BUS_ARB_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: slot contents, rotating priority index, grant history.
    bit          m_vld;
    bit          m_op;
    bit [DW-1:0] m_data;
    bit [IW-1:0] m_src;
    bit [IW-1:0] m_tgt;
    int          m_ptr;
    int          m_stall;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            in_opcode[i]           = 1'($urandom_range(0, 1));
            in_data[i*DW +: DW]    = $urandom;
            in_src_id[i*IW +: IW]  = 4'($urandom_range(0, 15));
            in_tgt_id[i*IW +: IW]  = 4'($urandom_range(0, 15));
        end
    endtask

    // First valid input at or after m_ptr, going round the ring; -1 if none.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: drive at negedge, check in_rdy, advance model at posedge, check outputs.
    task automatic cycle(input logic [N-1:0] v, input logic ordy, input logic r, input bit rnd);
        int           g;
        bit           free;
        logic [N-1:0] exp_rdy;
        if (rnd) rand_payload();
        in_vld  = v;
        out_rdy = ordy;
        rst     = r;
        #1;
        free    = !m_vld || ordy;
        g       = model_pick(v);
        exp_rdy = '0;
        if (!r && free && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_stall = 0;
        end else if (m_vld && !ordy && m_stall < 16'hFFFF) begin
            m_stall = m_stall + 1;
        end
        if (r) begin
            m_vld = 0; m_op = 0; m_data = 0; m_src = 0; m_tgt = 0; m_ptr = 0;
        end else if (exp_rdy != '0) begin
            m_vld  = 1;
            m_op   = in_opcode[g];
            m_data = in_data[g*DW +: DW];
            m_src  = in_src_id[g*IW +: IW];
            m_tgt  = in_tgt_id[g*IW +: IW];
            m_ptr  = (g + 1) % N;
            grant_log.push_back(g);
        end else if (ordy) begin
            m_vld = 0;
        end
        @(negedge clk);
        chk("out_vld",    64'(out_vld),    64'(m_vld));
        chk("out_opcode", 64'(out_opcode), 64'(m_op));
        chk("out_data",   64'(out_data),   64'(m_data));
        chk("out_src_id", 64'(out_src_id), 64'(m_src));
        chk("out_tgt_id", 64'(out_tgt_id), 64'(m_tgt));
`ifdef TOY_BUS_ARB_STALL_CNT_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        in_vld    = '0;
        out_rdy   = 1'b0;
        in_opcode = '0;
        in_data   = '0;
        in_src_id = '0;
        in_tgt_id = '0;
        m_vld = 0; m_op = 0; m_data = 0; m_src = 0; m_tgt = 0; m_ptr = 0; m_stall = 0;
        @(negedge clk);

        // Reset state
        cycle('0, 1'b1, 1'b1, 1'b1);
        cycle('1, 1'b1, 1'b1, 1'b1);

        // Single input 1
        in_data[1*DW +: DW]   = 32'hA5A5_0001;
        in_tgt_id[1*IW +: IW] = 4'h6;
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        chk("single_data", 64'(out_data),   64'h0000_0000_A5A5_0001);
        chk("single_tgt",  64'(out_tgt_id), 64'h6);

        // Fairness: all valid, no backpressure, grants rotate 0..N-1 with no bubbles
        cycle('0, 1'b1, 1'b1, 1'b1);
        grant_log.delete();
        for (int c = 0; c < 2 * N; c++) cycle('1, 1'b1, 1'b0, 1'b1);
        chk("rr_count", 64'(grant_log.size()), 64'(2 * N));
        for (int c = 0; c < grant_log.size(); c++) chk("rr_order", 64'(grant_log[c]), 64'(c % N));

        // Backpressure for 5 cycles, then release accepts in the same cycle
        for (int c = 0; c < 5; c++) cycle('1, 1'b0, 1'b0, 1'b1);
        cycle('1, 1'b1, 1'b0, 1'b1);

        // Wrap: drive ptr to 3, then requests on 3 and 0
        cycle('0, 1'b1, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b0, 1'b1);
        cycle(4'b1001, 1'b1, 1'b0, 1'b1);
        chk("wrap_grant3", 64'(grant_log[grant_log.size()-1]), 64'd3);
        cycle(4'b1001, 1'b1, 1'b0, 1'b1);
        chk("wrap_grant0", 64'(grant_log[grant_log.size()-1]), 64'd0);

        // Reset in the middle of a stall
        cycle('1, 1'b1, 1'b0, 1'b1);
        cycle('1, 1'b0, 1'b0, 1'b1);
        cycle('1, 1'b0, 1'b1, 1'b1);
        chk("rst_stall_vld", 64'(out_vld), 64'd0);
        cycle('1, 1'b1, 1'b0, 1'b1);
        chk("rst_ptr0", 64'(grant_log[grant_log.size()-1]), 64'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), 1'b1);
        end

`ifdef TOY_BUS_ARB_STALL_CNT_EN
        // Saturation of the stall counter
        cycle('0, 1'b1, 1'b1, 1'b1);
        cycle(4'b0001, 1'b1, 1'b0, 1'b1);
        out_rdy = 1'b0;
        in_vld  = '0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        m_stall = 16'hFFFF;
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
        chk("stall_hold_vld", 64'(out_vld), 64'd1);
        cycle('0, 1'b0, 1'b1, 1'b1);
        chk("stall_rst", 64'(stall_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
